// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared constants, types and helpers for the register-file writeback path.
//   XLEN    default register data width
//   REG_AW  default register address width
//   IDW     width of a source index (covers up to 8 requesters)
//   wb_req_t  one writeback request: destination register plus data
//   rr_next   round-robin pointer advance, wrapping at the requester count
// ---------------------------------------------------------------------------
package rf_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int IDW    = 3;

   typedef struct packed {
      logic [REG_AW-1:0] addr;
      logic [XLEN-1:0]   data;
   } wb_req_t;

   // The source after the one just served becomes the first to be searched
   // next time; with a single requester this always returns 0.
   function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] ptr,
                                              input int              nreq);
      if (int'(ptr) + 1 >= nreq)
         return '0;
      else
         return ptr + 1'b1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. Searches the valid vector starting at
// ptr and wrapping modulo NREQ; the first valid source wins.
// Ports:
//   valid  in  NREQ  request vector
//   ptr    in  IDW   first index to search (always < NREQ)
//   grant  out NREQ  one-hot winner, zero when nothing is valid
//   idx    out IDW   binary index of the winner
//   any    out 1     some source is valid
// ---------------------------------------------------------------------------
module rr_arbiter
   import rf_pkg::*;
#(
   parameter int NREQ = 3
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   // Walk the requesters in rotated order and latch onto the first valid one.
   // The found flag keeps later candidates from overriding the winner.
   always_comb begin
      int  j;
      logic found;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr) + k) % NREQ;
         if (!found && valid[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = IDW'(j);
         end
      end
      any = found;
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the single register-file write port among NREQ writeback sources
// using round-robin arbitration and a valid/ready handshake per source. The
// winning request is registered into rf_w* so at most one write lands per
// cycle, one cycle after acceptance, at a sustained rate of one per cycle.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   hold                  stall: no grants while high
//   req_valid/req_ready   per-source handshake (ready is one-hot or zero)
//   req_addr/req_data     per-source packed destination register and data
//   rf_w_en/rf_wa/rf_wd   register-file write port
//   grant_id              source whose write is on rf_w*
// Optional feature (macro WB_FWD_EN): fwd_ra1/fwd_ra2 in, fwd_hit1/fwd_hit2
// and fwd_d1/fwd_d2 out, exposing the write landing this cycle to readers.
// ---------------------------------------------------------------------------
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int XLEN = rf_pkg::XLEN,
   parameter int AW   = rf_pkg::REG_AW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 hold,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*XLEN-1:0] req_data,
   output logic                 rf_w_en,
   output logic [AW-1:0]        rf_wa,
   output logic [XLEN-1:0]      rf_wd,
   output logic [2:0]           grant_id
`ifdef WB_FWD_EN
   ,
   input  logic [AW-1:0]        fwd_ra1,
   input  logic [AW-1:0]        fwd_ra2,
   output logic                 fwd_hit1,
   output logic                 fwd_hit2,
   output logic [XLEN-1:0]      fwd_d1,
   output logic [XLEN-1:0]      fwd_d2
`endif
);

   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  win_idx;
   logic [NREQ-1:0] win_onehot;
   logic            win_any;
   logic            fire;
   logic            wen_q;
   logic [AW-1:0]   sel_addr;
   logic [XLEN-1:0] sel_data;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .grant (win_onehot),
      .idx   (win_idx),
      .any   (win_any)
   );

   // A grant happens only when some source is valid, the pipeline is not
   // stalled and reset is released; ready never depends on the data.
   assign fire      = win_any && !hold && rst_n;
   assign req_ready = fire ? win_onehot : '0;

   // Steer the winning source's address and data with the one-hot grant so
   // no index can ever fall outside the packed buses.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_onehot[i]) begin
            sel_addr = req_addr[i*AW +: AW];
            sel_data = req_data[i*XLEN +: XLEN];
         end
      end
   end

   // Output stage and round-robin pointer. An x0 request still consumes its
   // slot and loads address/data, but does not raise the write enable. Idle
   // or stalled cycles drop the enable and keep the last address/data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wen_q    <= 1'b0;
         rf_wa    <= '0;
         rf_wd    <= '0;
         grant_id <= '0;
         rr_ptr   <= '0;
      end else if (fire) begin
         wen_q    <= (sel_addr != '0);
         rf_wa    <= sel_addr;
         rf_wd    <= sel_data;
         grant_id <= win_idx;
         rr_ptr   <= rr_next(win_idx, NREQ);
      end else begin
         wen_q    <= 1'b0;
      end
   end

   // The registered enable is masked by reset so a write still in flight
   // when reset is asserted never reaches the register file.
   assign rf_w_en = wen_q && rst_n;

`ifdef WB_FWD_EN
   // Bypass compare against the write landing this cycle; x0 never hits.
   assign fwd_hit1 = rf_w_en && (rf_wa == fwd_ra1) && (fwd_ra1 != '0);
   assign fwd_hit2 = rf_w_en && (rf_wa == fwd_ra2) && (fwd_ra2 != '0);
   assign fwd_d1   = rf_wd;
   assign fwd_d2   = rf_wd;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
// Self-checking bench for rf_wb_arbiter (NREQ=3, XLEN=32, AW=5). Directed
// scenario tasks plus a randomized run against a behavioural model that picks
// the valid source nearest the pointer in modular distance.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;
   import rf_pkg::*;

   localparam int N  = 3;
   localparam int AW = 5;
   localparam int XW = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            hold;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*AW-1:0] req_addr;
   logic [N*XW-1:0] req_data;
   logic            rf_w_en;
   logic [AW-1:0]   rf_wa;
   logic [XW-1:0]   rf_wd;
   logic [2:0]      grant_id;
`ifdef WB_FWD_EN
   logic [AW-1:0]   fwd_ra1, fwd_ra2;
   logic            fwd_hit1, fwd_hit2;
   logic [XW-1:0]   fwd_d1, fwd_d2;
`endif

   int total = 0;
   int bad   = 0;

   // Model state: what the write port should show after each edge.
   int            m_ptr;
   logic          m_wen;
   logic [AW-1:0] m_wa;
   logic [XW-1:0] m_wd;
   logic [2:0]    m_gid;

   rf_wb_arbiter #(.NREQ(N), .XLEN(XW), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .hold      (hold),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .rf_w_en   (rf_w_en),
      .rf_wa     (rf_wa),
      .rf_wd     (rf_wd),
      .grant_id  (grant_id)
`ifdef WB_FWD_EN
      ,
      .fwd_ra1   (fwd_ra1),
      .fwd_ra2   (fwd_ra2),
      .fwd_hit1  (fwd_hit1),
      .fwd_hit2  (fwd_hit2),
      .fwd_d1    (fwd_d1),
      .fwd_d2    (fwd_d2)
`endif
   );

   always #5 clk = ~clk;

   // The winner is the valid source with the smallest forward distance from
   // the pointer around the ring.
   function automatic logic [N-1:0] model_ready();
      int best;
      int bestd;
      int d;
      best  = -1;
      bestd = N;
      if (!rst_n || hold) return '0;
      for (int i = 0; i < N; i++) begin
         if (req_valid[i]) begin
            d = (i - m_ptr + N) % N;
            if (d < bestd) begin
               bestd = d;
               best  = i;
            end
         end
      end
      if (best < 0) return '0;
      return N'(1) << best;
   endfunction

   task automatic model_apply(input logic [N-1:0] g);
      wb_req_t r;
      if (!rst_n) begin
         m_wen = 1'b0; m_wa = '0; m_wd = '0; m_gid = '0; m_ptr = 0;
      end else if (g != '0) begin
         for (int i = 0; i < N; i++) begin
            if (g[i]) begin
               r.addr = req_addr[i*AW +: AW];
               r.data = req_data[i*XW +: XW];
               m_wen  = (r.addr != '0);
               m_wa   = r.addr;
               m_wd   = r.data;
               m_gid  = 3'(i);
               m_ptr  = (i + 1) % N;
            end
         end
      end else begin
         m_wen = 1'b0;
      end
   endtask

   task automatic tick(output logic [N-1:0] g);
      g = model_ready();
      @(posedge clk);
      model_apply(g);
      #1;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XW-1:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*XW +: XW] = d;
   endtask

   task automatic test_reset();
      logic [N-1:0] g;
      rst_n = 1'b0; hold = 1'b0; req_valid = '1;
      req_addr = '0; req_data = '0;
      set_req(0, 5'd3, 32'h100); set_req(1, 5'd4, 32'h101); set_req(2, 5'd6, 32'h102);
      tick(g); tick(g);
      @(negedge clk);
      total++; if (req_ready !== 3'b000) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=000", req_ready); end
      total++; if (rf_w_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_wen got=%b exp=0", rf_w_en); end
      total++; if (rf_wa !== 5'd0 || rf_wd !== 32'd0) begin bad++; $display("[TB] FAIL reset_wa_wd got=%0d/%h exp=0/0", rf_wa, rf_wd); end
      total++; if (grant_id !== 3'd0) begin bad++; $display("[TB] FAIL reset_gid got=%0d exp=0", grant_id); end
      rst_n = 1'b1;
      #1;
      total++; if (req_ready !== 3'b001) begin bad++; $display("[TB] FAIL reset_first_grant got=%b exp=001", req_ready); end
      tick(g);
      req_valid = '0;
      @(negedge clk);
      total++; if (rf_w_en !== 1'b1 || grant_id !== 3'd0 || rf_wa !== 5'd3) begin
         bad++; $display("[TB] FAIL reset_first_write got=%b/%0d/%0d exp=1/0/3", rf_w_en, grant_id, rf_wa); end
   endtask

   task automatic test_single();
      logic [N-1:0] g;
      set_req(1, 5'd5, 32'hDEADBEEF);
      req_valid = 3'b010;
      @(negedge clk);
      total++; if (req_ready !== 3'b010) begin bad++; $display("[TB] FAIL single_ready got=%b exp=010", req_ready); end
      tick(g);
      req_valid = '0;
      @(negedge clk);
      total++; if (rf_w_en !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'hDEADBEEF || grant_id !== 3'd1) begin
         bad++; $display("[TB] FAIL single_write got=%b/%0d/%h/%0d exp=1/5/deadbeef/1", rf_w_en, rf_wa, rf_wd, grant_id); end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] g;
      // Serve source 2 alone so the pointer sits at 0 before the burst.
      set_req(2, 5'd9, 32'h9);
      req_valid = 3'b100;
      tick(g);
      for (int i = 0; i < N; i++) set_req(i, 5'(8 + i), 32'(16 * i));
      req_valid = '1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         total++; if (req_ready !== 3'(1 << (k % 3))) begin
            bad++; $display("[TB] FAIL rr_ready k=%0d got=%b exp=%b", k, req_ready, 3'(1 << (k % 3))); end
         if (k > 0) begin
            total++; if (rf_w_en !== 1'b1 || grant_id !== 3'((k - 1) % 3)) begin
               bad++; $display("[TB] FAIL rr_write k=%0d got=%b/%0d exp=1/%0d", k, rf_w_en, grant_id, (k - 1) % 3); end
         end
         tick(g);
         set_req(k % 3, 5'(8 + k % 3), 32'(16 * (k % 3) + k + 1));
      end
      req_valid = '0;
      @(negedge clk);
      total++; if (rf_w_en !== 1'b1 || grant_id !== 3'd2) begin
         bad++; $display("[TB] FAIL rr_last got=%b/%0d exp=1/2", rf_w_en, grant_id); end
   endtask

   task automatic test_x0();
      logic [N-1:0] g;
      set_req(0, 5'd0, 32'h1);
      req_valid = 3'b001;
      @(negedge clk);
      total++; if (req_ready !== 3'b001) begin bad++; $display("[TB] FAIL x0_ready got=%b exp=001", req_ready); end
      tick(g);
      req_valid = '0;
      @(negedge clk);
      total++; if (rf_w_en !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 32'h1) begin
         bad++; $display("[TB] FAIL x0_write got=%b/%0d/%h exp=0/0/1", rf_w_en, rf_wa, rf_wd); end
      tick(g);
      @(negedge clk);
      total++; if (rf_w_en !== 1'b0 || rf_wd !== 32'h1) begin
         bad++; $display("[TB] FAIL idle_keep got=%b/%h exp=0/1", rf_w_en, rf_wd); end
      req_valid = '1;
      #1;
      total++; if (req_ready !== 3'b010) begin bad++; $display("[TB] FAIL x0_ptr_adv got=%b exp=010", req_ready); end
      req_valid = '0;
   endtask

   task automatic test_hold();
      logic [N-1:0] g;
      set_req(2, 5'd12, 32'hA5A5);
      req_valid = 3'b100;
      hold = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++; if (req_ready !== 3'b000) begin bad++; $display("[TB] FAIL hold_ready c=%0d got=%b exp=000", c, req_ready); end
         tick(g);
         @(negedge clk);
         total++; if (rf_w_en !== 1'b0) begin bad++; $display("[TB] FAIL hold_wen c=%0d got=%b exp=0", c, rf_w_en); end
      end
      hold = 1'b0;
      #1;
      total++; if (req_ready !== 3'b100) begin bad++; $display("[TB] FAIL hold_release got=%b exp=100", req_ready); end
      tick(g);
      req_valid = '0;
      @(negedge clk);
      total++; if (rf_w_en !== 1'b1 || grant_id !== 3'd2 || rf_wa !== 5'd12) begin
         bad++; $display("[TB] FAIL hold_write got=%b/%0d/%0d exp=1/2/12", rf_w_en, grant_id, rf_wa); end
   endtask

`ifdef WB_FWD_EN
   task automatic test_fwd();
      logic [N-1:0] g;
      set_req(0, 5'd7, 32'h55);
      req_valid = 3'b001;
      tick(g);
      req_valid = '0;
      fwd_ra1 = 5'd7; fwd_ra2 = 5'd0;
      @(negedge clk);
      total++; if (fwd_hit1 !== 1'b1 || fwd_d1 !== 32'h55 || fwd_hit2 !== 1'b0) begin
         bad++; $display("[TB] FAIL fwd_hit got=%b/%h/%b exp=1/55/0", fwd_hit1, fwd_d1, fwd_hit2); end
      fwd_ra2 = 5'd7;
      #1;
      total++; if (fwd_hit2 !== 1'b1 || fwd_d2 !== 32'h55) begin
         bad++; $display("[TB] FAIL fwd_hit2 got=%b/%h exp=1/55", fwd_hit2, fwd_d2); end
      tick(g);
      @(negedge clk);
      total++; if (fwd_hit1 !== 1'b0) begin bad++; $display("[TB] FAIL fwd_idle got=%b exp=0", fwd_hit1); end
   endtask
`endif

   task automatic test_reset_midstream();
      logic [N-1:0] g;
      set_req(1, 5'd20, 32'hCAFE);
      req_valid = 3'b010;
      @(negedge clk);
      total++; if (req_ready !== 3'b010) begin bad++; $display("[TB] FAIL mid_accept got=%b exp=010", req_ready); end
      tick(g);
      req_valid = '0;
      rst_n = 1'b0;
      #1;
      total++; if (rf_w_en !== 1'b0) begin bad++; $display("[TB] FAIL mid_drop got=%b exp=0", rf_w_en); end
      tick(g);
      @(negedge clk);
      total++; if (rf_w_en !== 1'b0 || rf_wa !== 5'd0 || grant_id !== 3'd0) begin
         bad++; $display("[TB] FAIL mid_reset got=%b/%0d/%0d exp=0/0/0", rf_w_en, rf_wa, grant_id); end
      rst_n = 1'b1;
      tick(g);
   endtask

   task automatic test_random();
      logic [N-1:0] g;
      logic [N-1:0] exp_rdy;
      logic [AW-1:0] a;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && ($urandom % 2 == 0)) begin
               a = ($urandom % 6 == 0) ? 5'd0 : 5'($urandom);
               set_req(i, a, 32'($urandom));
               req_valid[i] = 1'b1;
            end
         end
         hold = ($urandom % 5 == 0);
         @(negedge clk);
         exp_rdy = model_ready();
         total++; if (req_ready !== exp_rdy || !$onehot0(req_ready)) begin
            bad++; $display("[TB] FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
         total++; if (rf_w_en !== (m_wen && rst_n) || rf_wa !== m_wa || rf_wd !== m_wd || grant_id !== m_gid) begin
            bad++; $display("[TB] FAIL rand_port c=%0d got=%b/%0d/%h/%0d exp=%b/%0d/%h/%0d",
                            c, rf_w_en, rf_wa, rf_wd, grant_id, m_wen, m_wa, m_wd, m_gid); end
         tick(g);
         req_valid = req_valid & ~g;
      end
      hold = 1'b0;
      req_valid = '0;
   endtask

   initial begin
`ifdef WB_FWD_EN
      fwd_ra1 = '0; fwd_ra2 = '0;
`endif
      m_ptr = 0; m_wen = 1'b0; m_wa = '0; m_wd = '0; m_gid = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_x0();
      test_hold();
`ifdef WB_FWD_EN
      test_fwd();
`endif
      test_reset_midstream();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
